// File: rtl/dda_stream_tx.sv
// rtl/dda_stream_tx.sv - DDA-out stream transmitter: packs ray results, buffers them, frames one sweep
// Small FIFO between the DDA core and the AXI-stream master; tlast is set by ray count, not hcount.
module dda_stream_tx #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 180,
  parameter int DEPTH         = 4
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        frame_start_in,
  input  logic        dda_valid_in,
  input  logic [8:0]  dda_hcount_in,
  input  logic [15:0] dda_line_height_in,
  input  logic        dda_wall_type_in,
  input  logic [3:0]  dda_map_data_in,
  input  logic [15:0] dda_wall_x_in,
  output logic        dda_ready_out,
  output logic        m_axis_tvalid_out,
  output logic [37:0] m_axis_tdata_out,
  output logic        m_axis_tlast_out,
  input  logic        m_axis_tready_in,
  output logic        overflow_out,
  output logic        frame_done_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SCREEN_WIDTH);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_RAY   = CW'(SCREEN_WIDTH - 1);
  localparam logic [15:0]   HEIGHT_MAX = 16'(SCREEN_HEIGHT);

  typedef enum logic [1:0] {IDLE, ACCEPT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [38:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [CW-1:0] ray_cnt_q;
  logic          overflow_q;
  logic          ready, push, pop, drop, frame_open, done, last_ray;
  logic [15:0]   height_clamped;
  logic [37:0]   ray_word;

  assign last_ray       = (ray_cnt_q == LAST_RAY);
  assign height_clamped = (dda_line_height_in > HEIGHT_MAX) ? HEIGHT_MAX : dda_line_height_in;
  assign ray_word       = {dda_hcount_in, height_clamped[7:0], dda_wall_type_in,
                           dda_map_data_in, dda_wall_x_in};

  // Empty buffer forces zero outputs, so reset clears tdata/tlast without resetting the storage.
  assign m_axis_tvalid_out = (count_q != '0);
  assign {m_axis_tlast_out, m_axis_tdata_out} = m_axis_tvalid_out ? mem[rd_ptr_q] : 39'd0;
  assign pop            = m_axis_tvalid_out && m_axis_tready_in;
  assign drop           = dda_valid_in && !ready && (state_q != IDLE);
  assign dda_ready_out  = ready;
  assign overflow_out   = overflow_q;
  assign frame_done_out = done;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    push       = 1'b0;
    frame_open = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start_in) begin
          frame_open = 1'b1;
          state_d    = ACCEPT;
        end
      end
      ACCEPT: begin
        // Registered occupancy only: a pop in this cycle does not open a slot.
        ready = (count_q < FULL_CNT);
        push  = dda_valid_in && ready;
        if (push && last_ray) state_d = DRAIN;
      end
      DRAIN: begin
        if (count_q == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ray_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q  <= wr_ptr_q + 1'b1;
        ray_cnt_q <= ray_cnt_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (frame_open) begin
        ray_cnt_q  <= '0;
        overflow_q <= 1'b0;
      end else if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (push) mem[wr_ptr_q] <= {last_ray, ray_word};
  end

endmodule

// File: tb/tb_dda_stream_tx.sv
// tb/tb_dda_stream_tx.sv - randomized self-checking bench for dda_stream_tx against a queue model
module tb_dda_stream_tx;
  localparam int SW = 320;
  localparam int SH = 180;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fs, v, wt, tr;
  logic [8:0]  hc;
  logic [15:0] lh, wx;
  logic [3:0]  md;
  logic        ready, tvalid, tlast, ovf, fd;
  logic [37:0] tdata;

  always #5 clk = ~clk;

  dda_stream_tx #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .DEPTH(DEPTH)) dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .frame_start_in(fs),
    .dda_valid_in(v), .dda_hcount_in(hc), .dda_line_height_in(lh),
    .dda_wall_type_in(wt), .dda_map_data_in(md), .dda_wall_x_in(wx),
    .dda_ready_out(ready), .m_axis_tvalid_out(tvalid), .m_axis_tdata_out(tdata),
    .m_axis_tlast_out(tlast), .m_axis_tready_in(tr),
    .overflow_out(ovf), .frame_done_out(fd)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame phase flags, a word queue and a ray count.
  bit          m_acc, m_drain, m_ovf;
  int          m_cnt;
  logic [38:0] mq[$];
  int          beats, last_beats, last_idx, done_pulses, pushes;

  function automatic logic [37:0] pack();
    int h;
    h = (int'(lh) > SH) ? SH : int'(lh);
    return {hc, 8'(h), wt, md, wx};
  endfunction

  task automatic rand_ray();
    hc = 9'($urandom);
    lh = ($urandom % 3 == 0) ? 16'($urandom) : 16'($urandom_range(170, 190));
    wt = 1'($urandom);
    md = 4'($urandom);
    wx = 16'($urandom);
  endtask

  task automatic model_reset();
    mq.delete();
    m_acc = 0; m_drain = 0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic step();
    bit exp_ready, exp_valid, exp_done, idle, last;
    exp_ready = m_acc && (mq.size() < DEPTH);
    exp_valid = (mq.size() > 0);
    exp_done  = m_drain && (mq.size() == 0);
    idle      = !m_acc && !m_drain;
    chk("ready", ready, exp_ready);
    chk("tvalid", tvalid, exp_valid);
    if (exp_valid) begin
      chk("tdata", tdata, mq[0][37:0]);
      chk("tlast", tlast, mq[0][38]);
    end
    chk("overflow", ovf, m_ovf);
    chk("frame_done", fd, exp_done);
    if (tvalid && tr) begin
      beats++;
      if (tlast) begin
        last_beats++;
        last_idx = beats;
      end
    end
    if (fd) done_pulses++;
    if (ready && v) pushes++;
    if (exp_valid && tr) void'(mq.pop_front());
    if (v && exp_ready) begin
      last = (m_cnt == SW - 1);
      mq.push_back({last, pack()});
      m_cnt++;
      if (last) begin
        m_acc = 0;
        m_drain = 1;
      end
    end
    if (v && !exp_ready && !idle) m_ovf = 1;
    if (exp_done) m_drain = 0;
    if (idle && fs) begin
      m_acc = 1; m_cnt = 0; m_ovf = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    beats = 0; last_beats = 0; last_idx = 0; done_pulses = 0; pushes = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [37:0] sent[$];
    rst_n = 0; fs = 0; v = 0; tr = 0; hc = '0; lh = '0; wt = 0; md = '0; wx = '0;
    model_reset();
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_ready", ready, 0);
    chk("rst_overflow", ovf, 0);
    chk("rst_done", fd, 0);
    rst_n = 1;

    // Valid pulses with no frame open must be ignored.
    for (int i = 0; i < 8; i++) begin
      v = 1'($urandom); rand_ray(); step();
    end
    chk("idle_overflow", ovf, 0);
    chk("idle_tvalid", tvalid, 0);

    // Full sweep, back-to-back, starting with the packing cases.
    v = 0; tr = 1; fs = 1; step(); fs = 0;
    clear_stats();
    hc = 9'd5; lh = 16'd400; wt = 1; md = 4'd3; wx = 16'h1234; v = 1; step();
    chk("pack_clamp", tdata, {9'd5, 8'd180, 1'b1, 4'd3, 16'h1234});
    hc = 9'd6; lh = 16'd90; step();
    chk("pack_noclamp", tdata[28:21], 90);
    for (int i = 0; i < SW - 2; i++) begin
      rand_ray(); step();
    end
    v = 0;
    for (int k = 0; k < 20 && done_pulses == 0; k++) step();
    repeat (3) step();
    chk("sweep_beats", beats, SW);
    chk("sweep_tlast_count", last_beats, 1);
    chk("sweep_tlast_index", last_idx, SW);
    chk("sweep_done_pulses", done_pulses, 1);
    chk("sweep_idle_ready", ready, 0);

    // Backpressure: 6 rays offered into a stalled stream.
    clear_stats();
    tr = 0; fs = 1; step(); fs = 0;
    for (int i = 0; i < 6; i++) begin
      rand_ray(); v = 1; sent.push_back(pack()); step();
    end
    v = 0;
    chk("bp_accepted", pushes, 4);
    chk("bp_ready", ready, 0);
    chk("bp_overflow", ovf, 1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", tdata, sent[0]);
      step();
    end
    tr = 1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_order", tdata, sent[i]);
      step();
    end
    chk("bp_empty", tvalid, 0);

    // Push and pop together while two words are buffered.
    tr = 0; v = 1;
    rand_ray(); step();
    rand_ray(); step();
    tr = 1;
    for (int i = 0; i < 8; i++) begin
      chk("pp_ready", ready, 1);
      rand_ray(); step();
    end
    v = 0; beats = 0;
    for (int i = 0; i < 6; i++) step();
    chk("pp_drain_beats", beats, 2);

    // Random traffic until this sweep completes.
    done_pulses = 0;
    for (int k = 0; k < 4000 && done_pulses == 0; k++) begin
      v = ($urandom % 4) != 0; tr = ($urandom % 4) != 0; fs = ($urandom % 8) == 0;
      rand_ray(); step();
    end
    fs = 0; v = 0;
    chk("rand_frame_done", done_pulses, 1);
    step();

    // Reset asserted mid-DRAIN with three words buffered.
    tr = 1; fs = 1; step(); fs = 0; v = 1;
    for (int i = 0; i < SW - 3; i++) begin
      rand_ray(); step();
    end
    v = 0; step();
    tr = 0; v = 1;
    for (int i = 0; i < 3; i++) begin
      rand_ray(); step();
    end
    v = 0;
    chk("drain_ready", ready, 0);
    chk("drain_tvalid", tvalid, 1);
    rst_n = 0;
    #1;
    chk("async_tvalid", tvalid, 0);
    chk("async_tdata", tdata, 0);
    chk("async_tlast", tlast, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    clear_stats();
    tr = 1;
    for (int i = 0; i < 10; i++) begin
      v = 1'($urandom); rand_ray(); step();
    end
    chk("post_rst_beats", beats, 0);
    chk("post_rst_done", done_pulses, 0);
    chk("post_rst_overflow", ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dda_stream_tx.md
Name: dda_stream_tx

Overview:
- Transmit end of the DDA-out stream: accepts per-ray results from the DDA core, packs them into the 38-bit ray word, buffers them, and drives the AXI-stream master into the DDA-out FIFO.
- The flattening stage consumes that FIFO.
- Frames one sweep of SCREEN_WIDTH rays.
- Generates tlast on the final ray of the sweep, applies backpressure to the DDA core, and flags dropped rays.

Parameters:
- SCREEN_WIDTH, 320, rays per frame sweep.
- SCREEN_HEIGHT, 180, line-height clamp value.
- DEPTH, 4, buffer entries; power of 2, minimum 2.

Ports:
- pixel_clk_in  in  1  sole clock.
- rst_n_in  in  1  reset; asynchronous, active-low.
- frame_start_in  in  1  one-cycle pulse that opens a new sweep.
- dda_valid_in  in  1  ray result valid.
- dda_hcount_in  in  9  ray column.
- dda_line_height_in  in  16  unclamped line height.
- dda_wall_type_in  in  1  0 = X wall, 1 = Y wall.
- dda_map_data_in  in  4  map cell value.
- dda_wall_x_in  in  16  wall hit position.
- dda_ready_out  out  1  block can accept a ray this cycle.
- m_axis_tvalid_out  out  1  stream word valid.
- m_axis_tdata_out  out  38  packed ray word.
- m_axis_tlast_out  out  1  last ray of sweep.
- m_axis_tready_in  in  1  FIFO ready.
- overflow_out  out  1  sticky; a ray was dropped this frame.
- frame_done_out  out  1  one-cycle pulse when the sweep is fully transmitted.

Behaviour:
- Reset (async, rst_n_in low):
  - State = IDLE; buffer empty; ray counter = 0.
  - All outputs 0, including tdata and tlast. m_axis_tvalid_out drops immediately, without waiting for a clock edge.
  - Buffered data is discarded.
- Packing:
  - tdata[37:29] = hcount.
  - tdata[28:21] = min(line_height, SCREEN_HEIGHT), truncated to 8 bits after the clamp.
  - tdata[20] = wall_type.
  - tdata[19:16] = map_data.
  - tdata[15:0] = wall_x.
- FSM:
  - IDLE:
    - dda_ready_out = 0.
    - frame_start_in -> ACCEPT; clears ray counter and overflow_out.
  - ACCEPT:
    - dda_ready_out = 1 iff buffer occupancy < DEPTH. Occupancy is registered and a same-cycle pop does not free space.
    - Push on dda_valid_in && dda_ready_out.
    - The tlast bit stored with the entry = (ray counter == SCREEN_WIDTH-1); the counter then increments.
    - The push that stores tlast = 1 -> DRAIN.
  - DRAIN:
    - dda_ready_out = 0.
    - Buffer becomes empty via a pop -> frame_done_out pulses 1 cycle -> IDLE.
  - frame_start_in outside IDLE is ignored.
- Drop rule:
  - dda_valid_in while dda_ready_out = 0, in ACCEPT or DRAIN, drops the ray and sets overflow_out.
  - The ray counter does not advance on a drop.
  - dda_valid_in in IDLE is ignored and does not set overflow_out.
- Stream:
  - m_axis_tvalid_out = buffer not empty.
  - tdata and tlast come from the buffer head.
  - Pop on tvalid && tready.
  - Head data is stable while tvalid && !tready (AXI rule).
  - Latency: a ray pushed at edge N is visible on tvalid after edge N when the buffer was empty. Throughput is 1 word/cycle.
- Simultaneous push + pop: both take effect; occupancy unchanged.
- Order: strict FIFO. hcount values are passed through unchecked; tlast is count-based, not hcount-based.

Test Plan:
- Reset and idle:
  - Stimulus: reset, then dda_valid_in pulses with no frame_start.
  - Required: tvalid stays 0, dda_ready_out = 0, overflow_out = 0.
- Packing and clamp:
  - Stimulus: frame_start, then one ray with hcount 5, line_height 400, wall_type 1, map 3, wall_x 0x1234, tready = 1.
  - Required: next cycle tdata = {9'd5, 8'd180, 1'b1, 4'd3, 16'h1234}.
  - Required: line_height 90 packs as 90.
- Full sweep:
  - Stimulus: 320 back-to-back rays, tready = 1.
  - Required: exactly 320 beats; tlast = 1 only on beat 320.
  - Required: frame_done_out pulses once, 1 cycle after the last pop; state returns to IDLE.
- Backpressure:
  - Stimulus: tready = 0 with 6 rays offered.
  - Required: 4 accepted, dda_ready_out = 0, overflow_out = 1.
  - Required: head tdata is held; on release, 4 beats arrive in order.
- Simultaneous push/pop at occupancy 2:
  - Required: occupancy stays 2 and data order is preserved.
- Async reset mid-DRAIN with 3 words buffered:
  - Required: tvalid drops immediately.
  - Required: after release no stale word appears and no frame_done pulse occurs.
